bcd_display_scan: RTL

Time-multiplexed 7-segment display driver that sits directly downstream of the decade (mod-10) counter chain. It consumes the packed BCD digits produced by the counters and scans them one at a time onto a shared segment bus with one-hot digit enables. The block snapshots the input once per frame, blanks digit transitions, optionally blanks leading zeros, and shows a dash for non-BCD codes.

---
 rtl/bcd_display_scan.sv | 124 ++++++++++++
 1 files changed

// File: rtl/bcd_display_scan.sv
// Multiplexed 7-segment scanner for a packed BCD counter chain.
// One blank cycle between digit slots; frame snapshot; optional leading-zero blanking.
module bcd_display_scan #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  en,
  input  logic                  lzb,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick
);

  localparam int PCNT_W = $clog2(PRESCALE);
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(DIGITS - 1);

  logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] snap_q, snap_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                ftick_q, ftick_d;

  logic [3:0]          digit [DIGITS];
  logic [DIGITS-1:0]   lead_zero;
  logic                upper_zero;
  logic                tick;
  logic [IDX_W-1:0]    idx_inc;
  logic [3:0]          cur_digit;
  logic                cur_blank;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      digit[i] = snap_q[4*i +: 4];
    end
  end

  // lead_zero[i]: every snapshot digit from the MSD down to i is zero; bit 0 never blanks.
  always_comb begin
    lead_zero  = '0;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero   = upper_zero & (digit[i] == 4'h0);
      lead_zero[i] = upper_zero;
    end
  end

  always_comb begin
    tick      = en && (pcnt_q == PCNT_MAX);
    idx_inc   = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
    cur_digit = digit[idx_q];
    cur_blank = lzb && lead_zero[idx_q];

    pcnt_d  = pcnt_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    an_d    = DIGITS'(1) << idx_q;
    seg_d   = cur_blank ? 7'h00 : decode(cur_digit);
    ftick_d = 1'b0;

    if (en) begin
      pcnt_d = pcnt_q + PCNT_W'(1);
    end

    // Slot change: blank one cycle so the old segments never ghost onto the new digit.
    if (tick) begin
      pcnt_d  = '0;
      idx_d   = idx_inc;
      an_d    = '0;
      seg_d   = 7'h00;
      ftick_d = (idx_inc == '0);
      if (idx_inc == '0) begin
        snap_d = bcd_in;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pcnt_q  <= '0;
      idx_q   <= '0;
      snap_q  <= '0;
      seg_q   <= 7'h00;
      an_q    <= '0;
      ftick_q <= 1'b0;
    end else begin
      pcnt_q  <= pcnt_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      ftick_q <= ftick_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = ftick_q;

endmodule
